// File: rtl/mode_pkg.sv
// Shared mode constants, FSM state encoding and helpers for the mode switch controller.
package mode_pkg;

  localparam int MODE_W = 2;
  localparam int HOLD_W = 16;

  localparam logic [MODE_W-1:0] MODE_MAIN     = 2'b00;
  localparam logic [MODE_W-1:0] MODE_WELCOME  = 2'b01;
  localparam logic [MODE_W-1:0] MODE_SETTINGS = 2'b10;
  localparam logic [MODE_W-1:0] MODE_SERVICE  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_ACK     = 2'b01,
    ST_RELEASE = 2'b10,
    ST_HOLDOFF = 2'b11
  } state_t;

  // A target is only honoured if a mode module actually exists for it.
  function automatic logic mode_valid(input logic [MODE_W-1:0] m, input int num_modes);
    return (int'(m) < num_modes);
  endfunction

endpackage

// File: rtl/mode_holdoff_counter.sv
// Post-switch holdoff down-counter: load, saturating decrement, zero flag.
module mode_holdoff_counter
  import mode_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [HOLD_W-1:0] load_value,
  input  logic              dec,
  output logic [HOLD_W-1:0] count,
  output logic              zero
);

  logic [HOLD_W-1:0] count_r;

  // Counter register; load wins over decrement, and it never wraps below zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= 16'd0;
    end else if (load) begin
      count_r <= load_value;
    end else if (dec && (count_r != 16'd0)) begin
      count_r <= count_r - 16'd1;
    end else begin
      count_r <= count_r;
    end
  end

  assign count = count_r;
  assign zero  = (count_r == 16'd0);

endmodule

// File: rtl/mode_switch_controller.sv
// Arbitrates main-mode switch requests: only the active mode's owner may request a switch.
// Optional post-switch holdoff is compiled in with `define MODE_SWITCH_HOLDOFF_EN.
module mode_switch_controller
  import mode_pkg::*;
#(
  parameter int                NUM_MODES      = 4,
  parameter int                HOLDOFF_CYCLES = 16,
  parameter logic [MODE_W-1:0] RESET_MODE     = MODE_WELCOME
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_MODES-1:0]   mode_req,
  input  logic [2*NUM_MODES-1:0] mode_target,
  output logic [NUM_MODES-1:0]   mode_ack,
  output logic [MODE_W-1:0]      current_main_mode,
  output logic                   switching,
  output logic                   mode_changed
);

  if ((HOLDOFF_CYCLES < 1) || (HOLDOFF_CYCLES > 65535) || (NUM_MODES < 1) || (NUM_MODES > 4)) begin : g_bad_params
    $error("mode_switch_controller: parameter out of range");
  end

  localparam logic [NUM_MODES-1:0] ACK_ONE = {{(NUM_MODES-1){1'b0}}, 1'b1};

  state_t                state_r, state_next_s;
  logic [MODE_W-1:0]     mode_r, mode_next_s;
  logic [MODE_W-1:0]     old_idx_r, old_idx_next_s;
  logic [MODE_W-1:0]     tgt_r, tgt_next_s;
  logic [NUM_MODES-1:0]  ack_r, ack_next_s;
  logic                  changed_r, changed_next_s;
  logic                  switching_r, switching_next_s;
  logic                  req_cur_s, req_old_s;
  logic [MODE_W-1:0]     tgt_cur_s;

`ifdef MODE_SWITCH_HOLDOFF_EN
  logic                  hold_load_s, hold_zero_s;
  logic [HOLD_W-1:0]     hold_count_s;

  mode_holdoff_counter u_holdoff (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (hold_load_s),
    .load_value (HOLD_W'(HOLDOFF_CYCLES - 1)),
    .dec        (state_r == ST_HOLDOFF),
    .count      (hold_count_s),
    .zero       (hold_zero_s)
  );
`endif

  // Select the request/target of the active mode owner and the request of the latched owner.
  always_comb begin
    req_cur_s = 1'b0;
    req_old_s = 1'b0;
    tgt_cur_s = mode_r;
    for (int i = 0; i < NUM_MODES; i++) begin
      if (mode_r == MODE_W'(i)) begin
        req_cur_s = mode_req[i];
        tgt_cur_s = mode_target[2*i +: 2];
      end else begin
        req_cur_s = req_cur_s;
      end
      if (old_idx_r == MODE_W'(i)) begin
        req_old_s = mode_req[i];
      end else begin
        req_old_s = req_old_s;
      end
    end
  end

  // Next-state and next-output logic; all outputs are registered from these values.
  always_comb begin
    state_next_s   = state_r;
    mode_next_s    = mode_r;
    old_idx_next_s = old_idx_r;
    tgt_next_s     = tgt_r;
    ack_next_s     = '0;
    changed_next_s = 1'b0;
`ifdef MODE_SWITCH_HOLDOFF_EN
    hold_load_s    = 1'b0;
`endif
    case (state_r)
      ST_IDLE: begin
        if (req_cur_s) begin
          state_next_s   = ST_ACK;
          old_idx_next_s = mode_r;
          tgt_next_s     = tgt_cur_s;
          ack_next_s     = ACK_ONE << mode_r;
          if (mode_valid(tgt_cur_s, NUM_MODES) && (tgt_cur_s != mode_r)) begin
            mode_next_s    = tgt_cur_s;
            changed_next_s = 1'b1;
          end else begin
            mode_next_s = mode_r;
          end
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_ACK: begin
        state_next_s = ST_RELEASE;
        // Hold the mode from the latched target so later bus changes cannot leak in.
        if (mode_valid(tgt_r, NUM_MODES)) begin
          mode_next_s = tgt_r;
        end else begin
          mode_next_s = mode_r;
        end
      end
      ST_RELEASE: begin
        if (!req_old_s) begin
`ifdef MODE_SWITCH_HOLDOFF_EN
          state_next_s = ST_HOLDOFF;
          hold_load_s  = 1'b1;
`else
          state_next_s = ST_IDLE;
`endif
        end else begin
          state_next_s = ST_RELEASE;
        end
      end
      ST_HOLDOFF: begin
`ifdef MODE_SWITCH_HOLDOFF_EN
        if (hold_zero_s) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_HOLDOFF;
        end
`else
        state_next_s = ST_IDLE;
`endif
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
    switching_next_s = (state_next_s != ST_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      mode_r      <= RESET_MODE;
      old_idx_r   <= RESET_MODE;
      tgt_r       <= RESET_MODE;
      ack_r       <= '0;
      changed_r   <= 1'b0;
      switching_r <= 1'b0;
    end else begin
      state_r     <= state_next_s;
      mode_r      <= mode_next_s;
      old_idx_r   <= old_idx_next_s;
      tgt_r       <= tgt_next_s;
      ack_r       <= ack_next_s;
      changed_r   <= changed_next_s;
      switching_r <= switching_next_s;
    end
  end

  assign mode_ack          = ack_r;
  assign current_main_mode = mode_r;
  assign switching         = switching_r;
  assign mode_changed      = changed_r;

endmodule

// File: tb/tb_mode_switch_controller.sv
// Scoreboard bench for mode_switch_controller; follows MODE_SWITCH_HOLDOFF_EN if defined.
module tb_mode_switch_controller;

`ifdef MODE_SWITCH_HOLDOFF_EN
  localparam int H = 16;
`else
  localparam int H = 0;
`endif

  typedef struct packed {
    logic [3:0] ack;
    logic [1:0] mode;
    logic       changed;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic [3:0] mode_req;
  logic [7:0] mode_target;
  logic [3:0] mode_ack;
  logic [1:0] current_main_mode;
  logic       switching;
  logic       mode_changed;

  exp_t sb_q[$];
  int   checks;
  int   errors;

  mode_switch_controller #(
    .NUM_MODES      (4),
    .HOLDOFF_CYCLES (16),
    .RESET_MODE     (2'b01)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .mode_req          (mode_req),
    .mode_target       (mode_target),
    .mode_ack          (mode_ack),
    .current_main_mode (current_main_mode),
    .switching         (switching),
    .mode_changed      (mode_changed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observe up to 'bound' negedges for a nonzero ack; report how many were needed.
  task automatic wait_ack(input int bound, output int waited, output logic got);
    waited = 0;
    got    = 1'b0;
    for (int k = 1; k <= bound; k++) begin
      @(negedge clk);
      if (mode_ack !== 4'b0000) begin
        waited = k;
        got    = 1'b1;
        break;
      end
    end
  endtask

  // Pop the expected transaction and compare it with the ack cycle just observed.
  task automatic score_ack(input string name, input logic got, input int waited, input int exp_wait);
    exp_t e;
    checks++;
    if (!got || sb_q.size() == 0) begin
      errors++;
      $display("FAIL %s: ack seen=%0b queued=%0d, required ack within bound", name, got, sb_q.size());
      if (sb_q.size() != 0) e = sb_q.pop_front();
    end else begin
      e = sb_q.pop_front();
      if (mode_ack !== e.ack) begin
        errors++;
        $display("FAIL %s ack: got %b expected %b", name, mode_ack, e.ack);
      end
      checks++;
      if (current_main_mode !== e.mode) begin
        errors++;
        $display("FAIL %s mode: got %b expected %b", name, current_main_mode, e.mode);
      end
      checks++;
      if (mode_changed !== e.changed) begin
        errors++;
        $display("FAIL %s mode_changed: got %b expected %b", name, mode_changed, e.changed);
      end
      checks++;
      if (waited != exp_wait) begin
        errors++;
        $display("FAIL %s latency: got %0d cycles expected %0d", name, waited, exp_wait);
      end
    end
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (switching === 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (switching !== 1'b0) begin
      errors++;
      $display("FAIL %s idle: switching=%b after %0d cycles, expected 0", name, switching, n);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    mode_req = 4'b0000;
    mode_target = 8'h00;
    repeat (3) @(negedge clk);
    checks++;
    if (current_main_mode !== 2'b01) begin errors++; $display("FAIL reset mode: got %b expected 01", current_main_mode); end
    checks++;
    if (mode_ack !== 4'b0000) begin errors++; $display("FAIL reset ack: got %b expected 0000", mode_ack); end
    checks++;
    if (switching !== 1'b0) begin errors++; $display("FAIL reset switching: got %b expected 0", switching); end
    checks++;
    if (mode_changed !== 1'b0) begin errors++; $display("FAIL reset mode_changed: got %b expected 0", mode_changed); end
  endtask

  // Request in the first cycle after reset, then hold req 4 cycles past the ack.
  task automatic test_first_request;
    int w, cnt;
    logic got;
    rst_n = 1'b1;
    mode_req = 4'b0010;
    mode_target = 8'b0000_1000;
    sb_q.push_back('{ack: 4'b0010, mode: 2'b10, changed: 1'b1});
    wait_ack(10, w, got);
    score_ack("first_req", got, w, 1);
    checks++;
    if (switching !== 1'b1) begin errors++; $display("FAIL first_req switching: got %b expected 1", switching); end
    cnt = 1;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      if (k == 1) begin
        checks++;
        if (mode_ack !== 4'b0000 || mode_changed !== 1'b0) begin
          errors++;
          $display("FAIL first_req pulse: ack=%b changed=%b expected 0000/0", mode_ack, mode_changed);
        end
      end
      if (switching !== 1'b1) break;
      cnt++;
      if (k == 4) mode_req = 4'b0000;
    end
    checks++;
    if (cnt != 5 + H) begin errors++; $display("FAIL switch_len: got %0d cycles expected %0d", cnt, 5 + H); end
    checks++;
    if (current_main_mode !== 2'b10) begin errors++; $display("FAIL first_req hold mode: got %b expected 10", current_main_mode); end
  endtask

  task automatic test_reset_mid;
    int w, spurious;
    logic got;
    mode_req = 4'b0100;
    mode_target = 8'b0011_0000;
    sb_q.push_back('{ack: 4'b0100, mode: 2'b11, changed: 1'b1});
    wait_ack(10, w, got);
    score_ack("mid_req", got, w, 1);
    mode_req = 4'b0000;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (current_main_mode !== 2'b01 || switching !== 1'b0 || mode_ack !== 4'b0000 || mode_changed !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: mode=%b sw=%b ack=%b chg=%b expected 01/0/0000/0",
               current_main_mode, switching, mode_ack, mode_changed);
    end
    @(negedge clk);
    rst_n = 1'b1;
    spurious = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (mode_ack !== 4'b0000 || mode_changed !== 1'b0 || switching !== 1'b0) spurious++;
    end
    checks++;
    if (spurious != 0) begin errors++; $display("FAIL post_reset quiet: got %0d active cycles expected 0", spurious); end
  endtask

  task automatic test_ignore_other;
    int bad;
    mode_req = 4'b0100;
    mode_target = 8'b0000_0000;
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      checks++;
      if (mode_ack !== 4'b0000 || current_main_mode !== 2'b01) begin
        errors++;
        bad++;
        $display("FAIL ignore_other: ack=%b mode=%b expected 0000/01", mode_ack, current_main_mode);
      end
    end
    mode_req = 4'b0000;
    @(negedge clk);
  endtask

  task automatic test_same_target;
    int w;
    logic got;
    mode_req = 4'b0010;
    mode_target = 8'b0000_0100;
    sb_q.push_back('{ack: 4'b0010, mode: 2'b01, changed: 1'b0});
    wait_ack(10, w, got);
    score_ack("same_tgt", got, w, 1);
    mode_req = 4'b0000;
    @(negedge clk);
    checks++;
    if (mode_ack !== 4'b0000 || current_main_mode !== 2'b01) begin
      errors++;
      $display("FAIL same_tgt after: ack=%b mode=%b expected 0000/01", mode_ack, current_main_mode);
    end
    wait_idle("same_tgt");
  endtask

  // Requester 2 asks during release/holdoff; its ack must wait the full minimum spacing.
  task automatic test_back_to_back;
    int w;
    logic got;
    mode_req = 4'b0010;
    mode_target = 8'b0011_1000;
    sb_q.push_back('{ack: 4'b0010, mode: 2'b10, changed: 1'b1});
    wait_ack(10, w, got);
    score_ack("b2b_first", got, w, 1);
    mode_req = 4'b0100;
    mode_target = 8'b0011_0000;
    sb_q.push_back('{ack: 4'b0100, mode: 2'b11, changed: 1'b1});
    @(negedge clk);
    checks++;
    if (current_main_mode !== 2'b10 || mode_ack !== 4'b0000) begin
      errors++;
      $display("FAIL b2b target_change: mode=%b ack=%b expected 10/0000", current_main_mode, mode_ack);
    end
    wait_ack(100, w, got);
    score_ack("b2b_second", got, w, H + 2);
    mode_req = 4'b0000;
    @(negedge clk);
    checks++;
    if (mode_ack !== 4'b0000 || mode_changed !== 1'b0) begin
      errors++;
      $display("FAIL b2b pulse: ack=%b changed=%b expected 0000/0", mode_ack, mode_changed);
    end
    wait_idle("b2b");
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_first_request();
    test_reset_mid();
    test_ignore_other();
    test_same_target();
    test_back_to_back();
    checks++;
    if (sb_q.size() != 0) begin errors++; $display("FAIL scoreboard leftover: got %0d expected 0", sb_q.size()); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
